// File: rtl/sync_to_mtncl_tx_if.sv
// Handshake and dual-rail bus between a clocked producer and the first MTNCL rank.
// slave = injection stage, master = clocked upstream plus MTNCL Ko source.
interface sync_to_mtncl_tx_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [WIDTH-1:0] dr_d0;
   logic [WIDTH-1:0] dr_d1;
   logic             sleep_out;
   logic             ko_in;

   modport master (
      output in_valid, in_data, ko_in,
      input  in_ready, dr_d0, dr_d1, sleep_out
   );

   modport slave (
      input  in_valid, in_data, ko_in,
      output in_ready, dr_d0, dr_d1, sleep_out
   );
endinterface

// File: rtl/sync_to_mtncl_tx.sv
// Clocked valid/ready to MTNCL dual-rail DATA/NULL injector, paced by a synchronised Ko.
module sync_to_mtncl_tx #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 255,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   sync_to_mtncl_tx_if.slave bus,
   output logic             busy,
   output logic             timeout_err,
   output logic [CNT_W-1:0] xfer_cnt
);
   localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WAIT_W-1:0] TMO = WAIT_W'(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DATA, S_NULL} state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [WIDTH-1:0]       data_q, data_d;
   logic [WIDTH-1:0]       d0_q, d0_d, d1_q, d1_d;
   logic                   sleep_q, sleep_d;
   logic                   busy_q, busy_d;
   logic                   err_q, err_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [WAIT_W-1:0]      wait_q, wait_d;
   logic                   ko_s;
   logic                   ready;

   assign ko_s  = sync_q[SYNC_STAGES-1];
   assign ready = (state_q == S_IDLE) && ko_s;

   assign bus.in_ready  = ready;
   assign bus.dr_d0     = d0_q;
   assign bus.dr_d1     = d1_q;
   assign bus.sleep_out = sleep_q;
   assign busy          = busy_q;
   assign timeout_err   = err_q;
   assign xfer_cnt      = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sync_q  <= '0;
         data_q  <= '0;
         d0_q    <= '0;
         d1_q    <= '0;
         sleep_q <= 1'b1;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.ko_in};
         data_q  <= data_d;
         d0_q    <= d0_d;
         d1_q    <= d1_d;
         sleep_q <= sleep_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      wait_d  = wait_q;
      err_d   = err_q;

      case (state_q)
         S_IDLE: begin
            if (bus.in_valid && ready) begin
               data_d  = bus.in_data;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            wait_d  = '0;
            state_d = S_DATA;
         end
         S_DATA: begin
            if (!ko_s) begin
               cnt_d   = cnt_q + 1'b1;
               wait_d  = '0;
               state_d = S_NULL;
            end else if (wait_q != TMO) begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_NULL: begin
            if (ko_s) begin
               state_d = S_IDLE;
            end else if (wait_q != TMO) begin
               wait_d = wait_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if ((TIMEOUT != 0) && ((state_d == S_DATA) || (state_d == S_NULL)) && (wait_d == TMO)) begin
         err_d = 1'b1;
      end

      // Output registers load from the next state so rails change on the same edge as the FSM.
      d0_d    = '0;
      d1_d    = '0;
      if ((state_d == S_SETUP) || (state_d == S_DATA)) begin
         d1_d = data_d;
         d0_d = ~data_d;
      end
      sleep_d = (state_d != S_DATA);
      busy_d  = (state_d != S_IDLE);
   end
endmodule

// File: tb/tb_sync_to_mtncl_tx.sv
// Directed and randomized bench for sync_to_mtncl_tx with a queue-based reference model.
module tb_sync_to_mtncl_tx;
   localparam int unsigned W   = 8;
   localparam int unsigned TMO = 16;
   localparam int unsigned CW  = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          busy;
   logic          timeout_err;
   logic [CW-1:0] xfer_cnt;

   sync_to_mtncl_tx_if #(.WIDTH(W)) bus ();

   sync_to_mtncl_tx #(
      .WIDTH(W),
      .SYNC_STAGES(2),
      .TIMEOUT(TMO),
      .CNT_W(CW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus),
      .busy(busy),
      .timeout_err(timeout_err),
      .xfer_cnt(xfer_cnt)
   );

   always #5 clk = ~clk;

   int        checks = 0;
   int        errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];
   int        exp_xfer = 0;
   int        hcount   = 0;
   bit        ko_auto  = 1'b0;
   int        ko_dly   = 4;
   bit        prev_sleep = 1'b1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // One clock step: invariants, wavefront monitor, optional Ko responder.
   task automatic tick();
      logic [7:0] inv;
      @(posedge clk);
      #1;
      inv = ~bus.dr_d1;
      check("rail_exclusive", {24'd0, bus.dr_d0 & bus.dr_d1}, 32'd0);
      if (!busy) check("idle_rails_zero", {16'd0, bus.dr_d0, bus.dr_d1}, 32'd0);
      if (!bus.sleep_out) check("data_complement", {24'd0, bus.dr_d0}, {24'd0, inv});
      if (prev_sleep && !bus.sleep_out) obs_q.push_back(bus.dr_d1);
      prev_sleep = bus.sleep_out;
      if (ko_auto && (bus.ko_in !== bus.sleep_out)) begin
         if (ko_dly == 0) begin
            bus.ko_in = bus.sleep_out;
            ko_dly    = $urandom_range(1, 6);
         end else begin
            ko_dly--;
         end
      end
   endtask

   task automatic send(input logic [7:0] w, input int budget, input bit drop);
      bit hs;
      hs = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      for (int n = 0; n < budget; n++) begin
         hs = bus.in_ready;
         tick();
         if (hs) break;
      end
      if (drop) bus.in_valid = 1'b0;
      check("handshake", {31'd0, hs}, 32'd1);
      if (hs) begin
         exp_q.push_back(w);
         exp_xfer++;
         hcount++;
      end
   endtask

   task automatic wait_xfer(input int budget);
      for (int n = 0; n < budget; n++) begin
         if (xfer_cnt == CW'(exp_xfer)) break;
         tick();
      end
      check("xfer_cnt", {16'd0, xfer_cnt}, 32'(exp_xfer));
   endtask

   task automatic wait_idle(input int budget);
      for (int n = 0; n < budget; n++) begin
         if (bus.in_ready && !busy) break;
         tick();
      end
      check("return_idle", {31'd0, bus.in_ready}, 32'd1);
   endtask

   task automatic compare_stream();
      check("stream_len", 32'(obs_q.size()), 32'(exp_q.size()));
      while ((obs_q.size() > 0) && (exp_q.size() > 0)) begin
         check("stream_word", {24'd0, obs_q.pop_front()}, {24'd0, exp_q.pop_front()});
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [7:0] w;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.ko_in    = 1'b1;
      rst_n        = 1'b0;

      // Reset and startup
      #12;
      check("rst_d0", {24'd0, bus.dr_d0}, 32'd0);
      check("rst_d1", {24'd0, bus.dr_d1}, 32'd0);
      check("rst_sleep", {31'd0, bus.sleep_out}, 32'd1);
      check("rst_ready", {31'd0, bus.in_ready}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_err", {31'd0, timeout_err}, 32'd0);
      check("rst_xfer", {16'd0, xfer_cnt}, 32'd0);
      tick();
      #1 rst_n = 1'b1;
      tick();
      check("startup_ready_edge1", {31'd0, bus.in_ready}, 32'd0);
      tick();
      check("startup_ready_edge2", {31'd0, bus.in_ready}, 32'd1);

      // Single word with exact latency
      send(8'hA5, 4, 1'b1);
      check("setup_d1", {24'd0, bus.dr_d1}, 32'hA5);
      check("setup_d0", {24'd0, bus.dr_d0}, 32'h5A);
      check("setup_sleep", {31'd0, bus.sleep_out}, 32'd1);
      check("setup_busy", {31'd0, busy}, 32'd1);
      tick();
      check("data_sleep", {31'd0, bus.sleep_out}, 32'd0);
      check("data_d1", {24'd0, bus.dr_d1}, 32'hA5);
      tick();
      tick();
      bus.ko_in = 1'b0;
      tick();
      tick();
      check("ko_latency_hold_sleep", {31'd0, bus.sleep_out}, 32'd0);
      check("ko_latency_hold_xfer", {16'd0, xfer_cnt}, 32'd0);
      tick();
      check("null_d0", {24'd0, bus.dr_d0}, 32'd0);
      check("null_d1", {24'd0, bus.dr_d1}, 32'd0);
      check("null_sleep", {31'd0, bus.sleep_out}, 32'd1);
      check("null_xfer", {16'd0, xfer_cnt}, 32'd1);
      bus.ko_in = 1'b1;
      tick();
      tick();
      check("null_ready_hold", {31'd0, bus.in_ready}, 32'd0);
      check("null_busy_hold", {31'd0, busy}, 32'd1);
      tick();
      check("idle_ready", {31'd0, bus.in_ready}, 32'd1);
      check("idle_busy", {31'd0, busy}, 32'd0);
      compare_stream();

      // Streaming with in_valid held high
      ko_auto = 1'b1;
      ko_dly  = 4;
      hcount  = 0;
      send(8'h00, 100, 1'b0);
      send(8'hFF, 100, 1'b0);
      send(8'h3C, 100, 1'b1);
      wait_xfer(200);
      check("stream_handshakes", 32'(hcount), 32'd3);
      compare_stream();

      // Randomized words, gaps and Ko delays
      for (int k = 0; k < 20; k++) begin
         for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
         w = 8'($urandom);
         send(w, 100, 1'b1);
      end
      wait_xfer(400);
      wait_idle(100);
      compare_stream();
      check("no_timeout_in_stream", {31'd0, timeout_err}, 32'd0);

      // Backpressure: Ko held low from reset
      ko_auto    = 1'b0;
      bus.ko_in  = 1'b0;
      rst_n      = 1'b0;
      prev_sleep = 1'b1;
      exp_xfer   = 0;
      tick();
      rst_n        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h11;
      for (int n = 0; n < 50; n++) begin
         tick();
         check("bp_ready", {31'd0, bus.in_ready}, 32'd0);
         check("bp_rails", {16'd0, bus.dr_d0, bus.dr_d1}, 32'd0);
      end
      check("bp_xfer", {16'd0, xfer_cnt}, 32'd0);

      // Timeout in S_DATA with Ko stuck high
      bus.ko_in = 1'b1;
      w = 8'($urandom);
      send(w, 10, 1'b1);
      tick();
      for (int n = 0; n < 15; n++) tick();
      check("tmo_before", {31'd0, timeout_err}, 32'd0);
      tick();
      check("tmo_set", {31'd0, timeout_err}, 32'd1);
      for (int n = 0; n < 5; n++) tick();
      check("tmo_still_data", {31'd0, bus.sleep_out}, 32'd0);
      bus.ko_in = 1'b0;
      wait_xfer(20);
      check("tmo_sticky", {31'd0, timeout_err}, 32'd1);
      bus.ko_in = 1'b1;
      wait_idle(20);
      compare_stream();

      // Asynchronous reset in the middle of S_DATA
      send(8'hA5, 10, 1'b1);
      tick();
      check("mid_data_sleep", {31'd0, bus.sleep_out}, 32'd0);
      check("mid_data_d1", {24'd0, bus.dr_d1}, 32'hA5);
      #2 rst_n = 1'b0;
      #1;
      check("arst_d0", {24'd0, bus.dr_d0}, 32'd0);
      check("arst_d1", {24'd0, bus.dr_d1}, 32'd0);
      check("arst_sleep", {31'd0, bus.sleep_out}, 32'd1);
      check("arst_xfer", {16'd0, xfer_cnt}, 32'd0);
      check("arst_err", {31'd0, timeout_err}, 32'd0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_ready", {31'd0, bus.in_ready}, 32'd0);
      #1 rst_n = 1'b1;
      prev_sleep = 1'b1;
      exp_xfer   = 0;
      exp_q.delete();
      obs_q.delete();
      tick();
      check("arst_ready_edge1", {31'd0, bus.in_ready}, 32'd0);
      tick();
      check("arst_ready_edge2", {31'd0, bus.in_ready}, 32'd1);
      ko_auto = 1'b1;
      send(8'h3C, 10, 1'b1);
      wait_xfer(60);
      wait_idle(60);
      compare_stream();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
